fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage feeding the instruction register. It owns the program counter and drives a synchronous-read instruction memory with 1-cycle latency. Each cycle it presents one instruction and its PC+1 (`instruction`, `pcInc0`) with a write strobe (`ir_enable`) to the downstream instruction register. It absorbs decode stalls with a one-entry hold buffer and handles branch redirects by injecting a NOP bubble.

## Interface
- `PC_W`, 9: program counter / instruction memory address width.
- `INST_W`, 24: instruction width.
- `RESET_PC`, 9'd0: first fetch address after reset.

- `clk`  in  1: clock.
- `rst`  in  1: reset. Synchronous, active-high; clock `clk`.
- `stall`  in  1: downstream cannot accept an instruction this cycle.
- `redirect_valid`  in  1: taken branch/jump; overrides `stall`.
- `redirect_pc`  in  PC_W: target address.
- `imem_addr`  out  PC_W: instruction memory read address (combinational).
- `imem_en`  out  1: read enable (combinational).
- `imem_rdata`  in  INST_W: read data, valid the cycle after an enabled read.
- `instruction`  out  INST_W: instruction to the instruction register.
- `pcInc0`  out  PC_W: address of `instruction` + 1.
- `ir_enable`  out  1: instruction register load strobe.

## Operation
- Registers:
  - `fpc`: next address to issue.
  - `inflight_v`/`inflight_pc`: read outstanding.
  - `buf_v`/`buf_inst`/`buf_pc`: hold buffer.
  - `state` ∈ {RUN, HOLD}.
- Reset: `fpc`=RESET_PC, `inflight_v`=0, `buf_v`=0, `state`=RUN. While `rst`=1: `ir_enable`=0, `instruction`=0, `pcInc0`=0, `imem_en`=0.
- Issue: when `imem_en`=1, then `inflight_pc`<=`imem_addr`, `fpc`<=`imem_addr`+1, `inflight_v`<=1. Otherwise `inflight_v`<=0.
- Priority 1, `redirect_valid`=1 (any state, any `stall`):
  - Output NOP bubble: `ir_enable`=1, `instruction`=0, `pcInc0`=0.
  - Discard in-flight read and hold buffer (`buf_v`<=0).
  - `imem_addr`=`redirect_pc`, `imem_en`=1; `state`<=RUN.
- Priority 2, `stall`=1:
  - `ir_enable`=0, `imem_en`=0, `fpc` unchanged.
  - If `inflight_v`: `buf_inst`<=`imem_rdata`, `buf_pc`<=`inflight_pc`, `buf_v`<=1.
  - `state`<=HOLD.
- Priority 3, no stall:
  - `imem_addr`=`fpc`, `imem_en`=1, `state`<=RUN.
  - Output source:
    - If `buf_v`: `buf_inst`, `buf_pc`+1, and `buf_v`<=0.
    - Else if `inflight_v`: `imem_rdata`, `inflight_pc`+1.
    - Else `ir_enable`=0.
- `buf_v` and `inflight_v` are never both 1. HOLD issues no reads, and leaving HOLD drains the buffer in the same cycle as the next issue.
- Arithmetic is mod 2^PC_W: PC 511 → `pcInc0`=0, next fetch 0. No overflow flag.
- NOP encoding is all-zero (opcode 0).

## Timing
- Memory latency 1 cycle; throughput 1 instruction/cycle with no stall.
- Reset release: `rst` low in cycle 0 → issue RESET_PC in cycle 0. Cycle 1: `ir_enable`=1 with mem[RESET_PC], `pcInc0`=RESET_PC+1.
- Redirect in cycle N: bubble in cycle N; target instruction in cycle N+1 with `pcInc0`=target+1.
- Stall over cycles N..M: no `ir_enable` in N..M. Cycle M+1 delivers the buffered instruction; cycle M+2 delivers the next sequential one. No instruction is lost or duplicated.
- Redirect while in HOLD: buffer discarded; identical to the RUN redirect.
- `rst` asserted mid-operation: all state cleared on that edge; the outstanding read is ignored.
- Outputs are combinational from registers, `stall`, `redirect_*` and `imem_rdata`. No combinational path from `imem_rdata` to `imem_*`.

## Structure
- Shared package `rk_core_pkg`: `PC_W`, `INST_W`, `NOP_INST`=24'h0, `fetch_state_t` {RUN, HOLD}.
- One sub-module: `fetch_hold_buf`, the one-entry instruction/PC hold register with capture/drain/clear. PC and FSM stay in `fetch_unit`.

## Test plan
- Reset, mem[k]=k+0x100, no stall: cycles 1..5 emit 0x100..0x104 with `pcInc0` 1..5.
- `stall` high for 3 cycles after the 3rd delivery: no `ir_enable` for 3 cycles; then 0x103, 0x104 in order, no gap, no duplicate.
- `redirect_valid`, `redirect_pc`=0x40 in cycle 4: cycle 4 emits `instruction`=0, `ir_enable`=1; cycle 5 emits mem[0x40] with `pcInc0`=0x41; cycle 6 emits mem[0x41].
- Redirect asserted together with `stall` while in HOLD: bubble emitted, buffer dropped, target delivered the next cycle.
- Redirect to 0x1FF: mem[0x1FF] emitted with `pcInc0`=0; next fetch address is 0.
- `rst` pulsed mid-stall: outputs 0 during reset; after release, fetch restarts at RESET_PC with no stale buffered instruction.

Source files
------------

// File: rtl/rk_core_pkg.sv
// rk_core_pkg: shared widths, NOP encoding and fetch FSM states
package rk_core_pkg;
    localparam int PC_W = 9;
    localparam int INST_W = 24;
    localparam logic [INST_W-1:0] NOP_INST = 24'h0;
    typedef enum logic {RUN, HOLD} fetch_state_t;
endpackage

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: one-entry instruction/PC hold register with capture, drain and clear
import rk_core_pkg::*;
module fetch_hold_buf (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              capture,
    input  logic              drain,
    input  logic [INST_W-1:0] d_inst,
    input  logic [PC_W-1:0]   d_pc,
    output logic              valid,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   pc
);
    // Clear wins over capture so a redirect always drops the held instruction.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid <= 1'b0;
        end else if (capture) begin
            valid <= 1'b1;
            inst  <= d_inst;
            pc    <= d_pc;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and instruction fetch with stall hold buffer and redirect bubble
import rk_core_pkg::*;
module fetch_unit #(
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic [PC_W-1:0]   imem_addr,
    output logic              imem_en,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] instruction,
    output logic [PC_W-1:0]   pcInc0,
    output logic              ir_enable
);
    logic [PC_W-1:0]   fpc;
    logic              inflight_v;
    logic [PC_W-1:0]   inflight_pc;
    logic              buf_v;
    logic [INST_W-1:0] buf_inst;
    logic [PC_W-1:0]   buf_pc;
    fetch_state_t      state;
    logic              use_buf;

    // The buffer can only be occupied while holding; gate on state for clarity.
    assign use_buf = buf_v && (state == HOLD);

    fetch_hold_buf u_hold (
        .clk     (clk),
        .rst     (rst),
        .clear   (redirect_valid),
        .capture (stall && !redirect_valid && inflight_v),
        .drain   (!stall && !redirect_valid && use_buf),
        .d_inst  (imem_rdata),
        .d_pc    (inflight_pc),
        .valid   (buf_v),
        .inst    (buf_inst),
        .pc      (buf_pc)
    );

    // Redirect beats stall; the output source prefers the held instruction over the in-flight read.
    always_comb begin
        imem_en     = 1'b0;
        imem_addr   = fpc;
        ir_enable   = 1'b0;
        instruction = NOP_INST;
        pcInc0      = '0;
        if (!rst && redirect_valid) begin
            imem_en   = 1'b1;
            imem_addr = redirect_pc;
            ir_enable = 1'b1;
        end else if (!rst && !stall) begin
            imem_en     = 1'b1;
            ir_enable   = use_buf || inflight_v;
            instruction = use_buf ? buf_inst : (inflight_v ? imem_rdata : NOP_INST);
            pcInc0      = use_buf ? buf_pc + 1'b1 : (inflight_v ? inflight_pc + 1'b1 : '0);
        end
    end

    // Issue tracking and RUN/HOLD state; a read not issued this cycle leaves nothing in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpc         <= RESET_PC;
            inflight_v  <= 1'b0;
            inflight_pc <= '0;
            state       <= RUN;
        end else begin
            inflight_v <= imem_en;
            if (imem_en) begin
                inflight_pc <= imem_addr;
                fpc         <= imem_addr + 1'b1;
            end
            state <= (stall && !redirect_valid) ? HOLD : RUN;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus a stall-pattern stream check for fetch_unit
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [8:0]  redirect_pc = '0;
    logic [8:0]  imem_addr;
    logic        imem_en;
    logic [23:0] imem_rdata;
    logic [23:0] instruction;
    logic [8:0]  pcInc0;
    logic        ir_enable;

    int n_pass = 0;
    int n_tot = 0;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_en        (imem_en),
        .imem_rdata     (imem_rdata),
        .instruction    (instruction),
        .pcInc0         (pcInc0),
        .ir_enable      (ir_enable)
    );

    always #5 clk = ~clk;

    // Memory model: mem[k] = k + 0x100, one-cycle synchronous read.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= 24'(imem_addr) + 24'h100;
    end

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [8:0]  rpc;
        logic        ir;
        logic [23:0] inst;
        logic [8:0]  pc;
        logic        en;
        logic [8:0]  addr;
    } vec_t;

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    endtask

    vec_t v[24];

    initial begin
        int e;
        int nonstall;
        v[0]  = '{1, 0, 0, 9'h000, 0, 24'h0,     9'h000, 0, 9'h000};
        v[1]  = '{1, 0, 0, 9'h000, 0, 24'h0,     9'h000, 0, 9'h000};
        v[2]  = '{0, 0, 0, 9'h000, 0, 24'h0,     9'h000, 1, 9'h000};
        v[3]  = '{0, 0, 0, 9'h000, 1, 24'h100,   9'h001, 1, 9'h001};
        v[4]  = '{0, 0, 0, 9'h000, 1, 24'h101,   9'h002, 1, 9'h002};
        v[5]  = '{0, 0, 0, 9'h000, 1, 24'h102,   9'h003, 1, 9'h003};
        v[6]  = '{0, 1, 0, 9'h000, 0, 24'h0,     9'h000, 0, 9'h000};
        v[7]  = '{0, 1, 0, 9'h000, 0, 24'h0,     9'h000, 0, 9'h000};
        v[8]  = '{0, 1, 0, 9'h000, 0, 24'h0,     9'h000, 0, 9'h000};
        v[9]  = '{0, 0, 0, 9'h000, 1, 24'h103,   9'h004, 1, 9'h004};
        v[10] = '{0, 0, 0, 9'h000, 1, 24'h104,   9'h005, 1, 9'h005};
        v[11] = '{0, 0, 1, 9'h040, 1, 24'h0,     9'h000, 1, 9'h040};
        v[12] = '{0, 0, 0, 9'h000, 1, 24'h140,   9'h041, 1, 9'h041};
        v[13] = '{0, 0, 0, 9'h000, 1, 24'h141,   9'h042, 1, 9'h042};
        v[14] = '{0, 1, 0, 9'h000, 0, 24'h0,     9'h000, 0, 9'h000};
        v[15] = '{0, 1, 1, 9'h010, 1, 24'h0,     9'h000, 1, 9'h010};
        v[16] = '{0, 0, 0, 9'h000, 1, 24'h110,   9'h011, 1, 9'h011};
        v[17] = '{0, 0, 1, 9'h1FF, 1, 24'h0,     9'h000, 1, 9'h1FF};
        v[18] = '{0, 0, 0, 9'h000, 1, 24'h2FF,   9'h000, 1, 9'h000};
        v[19] = '{0, 0, 0, 9'h000, 1, 24'h100,   9'h001, 1, 9'h001};
        v[20] = '{0, 1, 0, 9'h000, 0, 24'h0,     9'h000, 0, 9'h000};
        v[21] = '{1, 1, 0, 9'h000, 0, 24'h0,     9'h000, 0, 9'h000};
        v[22] = '{0, 0, 0, 9'h000, 0, 24'h0,     9'h000, 1, 9'h000};
        v[23] = '{0, 0, 0, 9'h000, 1, 24'h100,   9'h001, 1, 9'h001};

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            rst = v[i].rst;
            stall = v[i].stall;
            redirect_valid = v[i].redir;
            redirect_pc = v[i].rpc;
            #1;
            chk("ir_enable", i, int'(ir_enable), int'(v[i].ir));
            chk("imem_en", i, int'(imem_en), int'(v[i].en));
            if (v[i].en) chk("imem_addr", i, int'(imem_addr), int'(v[i].addr));
            if (v[i].ir || v[i].rst) begin
                chk("instruction", i, int'(instruction), int'(v[i].inst));
                chk("pcInc0", i, int'(pcInc0), int'(v[i].pc));
            end
        end

        // Sequential stream under a mixed stall pattern: every non-stalled cycle delivers exactly the next instruction.
        e = 1;
        nonstall = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            stall = (c % 5 == 1) || (c % 7 == 3) || (c % 7 == 4);
            redirect_valid = 1'b0;
            #1;
            if (!stall) nonstall++;
            if (ir_enable) begin
                chk("stream_inst", c, int'(instruction), 24'h100 + e);
                chk("stream_pc", c, int'(pcInc0), (e + 1) % 512);
                e++;
            end
        end
        chk("stream_count", 0, e - 1, nonstall);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
